// File: rtl/data_packer_if.sv
// Element-in / packed-word-out handshake bundle for data_packer.
// Signal names keep the packer's own i_/o_ perspective so both sides trace to one name.
interface data_packer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RATIO = 4
) ();

  logic                     o_input_ready;
  logic                     i_input_valid;
  logic [WIDTH-1:0]         i_input_data;
  logic                     i_input_last;

  logic                     i_output_ready;
  logic                     o_output_valid;
  logic [RATIO*WIDTH-1:0]   o_output_data;
  logic [RATIO-1:0]         o_output_mask;
  logic                     o_output_last;

  // Packer side
  modport slave (
    output o_input_ready,
    input  i_input_valid,
    input  i_input_data,
    input  i_input_last,
    input  i_output_ready,
    output o_output_valid,
    output o_output_data,
    output o_output_mask,
    output o_output_last
  );

  // Producer/consumer side
  modport master (
    input  o_input_ready,
    output i_input_valid,
    output i_input_data,
    output i_input_last,
    output i_output_ready,
    input  o_output_valid,
    input  o_output_data,
    input  o_output_mask,
    input  o_output_last
  );

endinterface

// File: rtl/data_packer.sv
// Packs RATIO elements of WIDTH bits into one word; a group may close early on
// i_input_last, yielding a partial word with a lane mask. One element/cycle sustained.
module data_packer #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RATIO   = 4,
  parameter int unsigned CNT_BIT = $clog2(RATIO)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  data_packer_if.slave  bus
);

  localparam int unsigned W_WORD = RATIO * WIDTH;

  logic [CNT_BIT-1:0] r_cnt;
  logic [W_WORD-1:0]  r_acc;
  logic [W_WORD-1:0]  r_data;
  logic [RATIO-1:0]   r_mask;
  logic               r_last;
  logic               r_valid;

  logic               w_input_ready;
  logic               w_accept;
  logic               w_lane_full;
  logic               w_complete;
  logic               w_out_xfer;
  logic [W_WORD-1:0]  w_merged;
  logic [RATIO-1:0]   w_mask;

  // Ready only depends on the output stage, never on the input side
  assign w_input_ready = !r_valid | bus.i_output_ready;
  assign w_accept      = w_input_ready & bus.i_input_valid;
  assign w_lane_full   = (r_cnt == CNT_BIT'(RATIO - 1));
  assign w_complete    = w_accept & (w_lane_full | bus.i_input_last);
  assign w_out_xfer    = r_valid & bus.i_output_ready;

  // Accumulator with the incoming element dropped into lane r_cnt and upper lanes cleared
  always_comb begin
    w_merged = r_acc;
    w_mask   = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (CNT_BIT'(k) == r_cnt) begin
        w_merged[k*WIDTH +: WIDTH] = bus.i_input_data;
        w_mask[k]                  = 1'b1;
      end else if (CNT_BIT'(k) > r_cnt) begin
        w_merged[k*WIDTH +: WIDTH] = '0;
      end else begin
        w_mask[k]                  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_data  <= '0;
      r_mask  <= '0;
      r_last  <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_complete) begin
      r_data  <= w_merged;
      r_mask  <= w_mask;
      r_last  <= bus.i_input_last;
      r_valid <= 1'b1;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      if (w_accept) begin
        r_acc <= w_merged;
        r_cnt <= r_cnt + CNT_BIT'(1);
      end
      // Word handed off with nothing new to replace it; payload may hold
      if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.o_input_ready  = w_input_ready;
  assign bus.o_output_valid = r_valid;
  assign bus.o_output_data  = r_data;
  assign bus.o_output_mask  = r_mask;
  assign bus.o_output_last  = r_last;

endmodule

// File: tb/tb_data_packer.sv
// Scenario bench for data_packer (WIDTH=8, RATIO=4): a lane model fills a scoreboard
// as elements are accepted; a forked monitor pops and compares on every word transfer.
module tb_data_packer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned RATIO = 4;
  localparam int unsigned W_WORD = WIDTH * RATIO;

  typedef struct packed {
    logic [W_WORD-1:0] data;
    logic [RATIO-1:0]  mask;
    logic              last;
  } word_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   cyc;

  word_t            sb[$];
  logic [WIDTH-1:0] m_lane[RATIO];
  int               m_cnt;

  data_packer_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

  data_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Lane model: record an accepted element, emit the expected word when a group closes
  function automatic void model_accept(input logic [WIDTH-1:0] d, input logic l);
    word_t w;
    m_lane[m_cnt] = d;
    if (m_cnt == RATIO - 1 || l) begin
      w = '0;
      for (int k = 0; k <= m_cnt; k++) begin
        w.data[k*WIDTH +: WIDTH] = m_lane[k];
        w.mask[k] = 1'b1;
      end
      w.last = l;
      sb.push_back(w);
      for (int k = 0; k < RATIO; k++) m_lane[k] = '0;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < RATIO; k++) m_lane[k] = '0;
    m_cnt = 0;
    sb.delete();
  endfunction

  // Entered at posedge+1; returns at posedge+1 right after the accepting edge
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    bus.i_input_valid = 1'b1;
    bus.i_input_data  = d;
    bus.i_input_last  = l;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = (bus.o_input_ready === 1'b1);
      @(posedge clk);
      n++;
    end
    if (ok) begin
      model_accept(d, l);
    end else begin
      checks++; errors++;
      $display("FAIL send_timeout: element %h not accepted within %0d cycles", d, n);
    end
    #1;
    bus.i_input_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d words still expected, required 0", name, sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard consumer plus hold-stability and non-empty-mask checks
  task automatic run_monitor();
    bit    p_hold;
    word_t p;
    word_t act;
    word_t exp;
    p_hold = 1'b0;
    p = '0;
    forever begin
      @(negedge clk);
      act = {bus.o_output_data, bus.o_output_mask, bus.o_output_last};
      if (rst_n !== 1'b1) begin
        p_hold = 1'b0;
      end else begin
        if (p_hold) begin
          checks++;
          if (bus.o_output_valid !== 1'b1 || act !== p) begin
            errors++;
            $display("FAIL hold_stable: valid=%b word=%h required valid=1 word=%h",
                     bus.o_output_valid, act, p);
          end
        end
        if (bus.o_output_valid === 1'b1) begin
          checks++;
          if (bus.o_output_mask === '0) begin
            errors++;
            $display("FAIL mask_nonzero: mask=%b while valid", bus.o_output_mask);
          end
          if (bus.i_output_ready === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL unexpected_word: got %h, required no word", act);
            end else begin
              exp = sb.pop_front();
              if (act !== exp) begin
                errors++;
                $display("FAIL word: data=%h mask=%b last=%b required data=%h mask=%b last=%b",
                         act.data, act.mask, act.last, exp.data, exp.mask, exp.last);
              end
            end
          end
        end
        p_hold = (bus.o_output_valid === 1'b1) && (bus.i_output_ready !== 1'b1);
        p      = act;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_input_valid  = 1'b0;
    bus.i_input_data   = '0;
    bus.i_input_last   = 1'b0;
    bus.i_output_ready = 1'b1;
    model_clear();
    #12;
    checks++;
    if (bus.o_output_valid !== 1'b0 || bus.o_output_data !== '0 ||
        bus.o_output_mask !== '0 || bus.o_output_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h mask=%b last=%b required all 0",
               bus.o_output_valid, bus.o_output_data, bus.o_output_mask, bus.o_output_last);
    end
    checks++;
    if (bus.o_input_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: o_input_ready=%b required 1", bus.o_input_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.o_input_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: o_input_ready=%b required 1", bus.o_input_ready);
    end
  endtask

  task automatic test_full_word();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_output_valid !== 1'b1 || bus.o_output_data !== 32'h44332211 ||
        bus.o_output_mask !== 4'b1111 || bus.o_output_last !== 1'b0) begin
      errors++;
      $display("FAIL full_word: valid=%b data=%h mask=%b last=%b required 1 44332211 1111 0",
               bus.o_output_valid, bus.o_output_data, bus.o_output_mask, bus.o_output_last);
    end
    @(negedge clk);
    checks++;
    if (bus.o_output_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_word_one_cycle: valid=%b required 0", bus.o_output_valid);
    end
    wait_empty("full_word");
  endtask

  task automatic test_partial_word();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.o_output_valid !== 1'b1 || bus.o_output_data !== 32'h0000BBAA ||
        bus.o_output_mask !== 4'b0011 || bus.o_output_last !== 1'b1) begin
      errors++;
      $display("FAIL partial_word: valid=%b data=%h mask=%b last=%b required 1 0000bbaa 0011 1",
               bus.o_output_valid, bus.o_output_data, bus.o_output_mask, bus.o_output_last);
    end
    @(posedge clk); #1;
    send(8'h5C, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.o_output_valid !== 1'b1 || bus.o_output_data !== 32'h0000005C ||
        bus.o_output_mask !== 4'b0001 || bus.o_output_last !== 1'b1) begin
      errors++;
      $display("FAIL single_word: valid=%b data=%h mask=%b last=%b required 1 0000005c 0001 1",
               bus.o_output_valid, bus.o_output_data, bus.o_output_mask, bus.o_output_last);
    end
    wait_empty("partial_word");
  endtask

  task automatic test_last_on_full();
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b0);
    send(8'hC3, 1'b0);
    send(8'hC4, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.o_output_data !== 32'hC4C3C2C1 || bus.o_output_mask !== 4'b1111 ||
        bus.o_output_last !== 1'b1) begin
      errors++;
      $display("FAIL last_on_full: data=%h mask=%b last=%b required c4c3c2c1 1111 1",
               bus.o_output_data, bus.o_output_mask, bus.o_output_last);
    end
    wait_empty("last_on_full");
  endtask

  task automatic test_backpressure();
    bus.i_output_ready = 1'b0;
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h63, 1'b0);
    send(8'h64, 1'b0);
    bus.i_input_valid = 1'b1;
    bus.i_input_data  = 8'h77;
    bus.i_input_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_input_ready !== 1'b0 || bus.o_output_valid !== 1'b1 ||
          bus.o_output_data !== 32'h64636261 || bus.o_output_mask !== 4'b1111 ||
          bus.o_output_last !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: ready=%b valid=%b data=%h mask=%b last=%b required 0 1 64636261 1111 0",
                 i, bus.o_input_ready, bus.o_output_valid, bus.o_output_data,
                 bus.o_output_mask, bus.o_output_last);
      end
    end
    @(posedge clk); #1;
    bus.i_output_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_input_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: o_input_ready=%b required 1", bus.o_input_ready);
    end
    @(posedge clk);
    model_accept(8'h77, 1'b1);
    #1;
    bus.i_input_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_output_valid !== 1'b1 || bus.o_output_data !== 32'h00000077 ||
        bus.o_output_mask !== 4'b0001) begin
      errors++;
      $display("FAIL no_bubble: valid=%b data=%h mask=%b required 1 00000077 0001",
               bus.o_output_valid, bus.o_output_data, bus.o_output_mask);
    end
    wait_empty("backpressure");
  endtask

  task automatic test_back_to_back();
    int start;
    start = cyc;
    for (int i = 1; i <= 12; i++) begin
      send(8'(i), i == 12);
    end
    checks++;
    if (cyc - start != 12) begin
      errors++;
      $display("FAIL stream_stall: took %0d cycles, required 12", cyc - start);
    end
    @(negedge clk);
    checks++;
    if (bus.o_output_data !== 32'h0C0B0A09 || bus.o_output_last !== 1'b1) begin
      errors++;
      $display("FAIL stream_last_word: data=%h last=%b required 0c0b0a09 1",
               bus.o_output_data, bus.o_output_last);
    end
    wait_empty("back_to_back");
  endtask

  task automatic test_random_backpressure();
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(8'($urandom), $urandom_range(0, 4) == 0);
        end
        send(8'hEE, 1'b1);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          bus.i_output_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.i_output_ready = 1'b1;
    wait_empty("random");
  endtask

  task automatic test_mid_reset();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_output_valid !== 1'b0 || bus.o_output_data !== '0 ||
        bus.o_output_mask !== '0 || bus.o_output_last !== 1'b0 ||
        bus.o_input_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%h mask=%b last=%b ready=%b required 0 0 0 0 1",
               bus.o_output_valid, bus.o_output_data, bus.o_output_mask,
               bus.o_output_last, bus.o_input_ready);
    end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.o_output_data !== 32'h13121110 || bus.o_output_mask !== 4'b1111) begin
      errors++;
      $display("FAIL post_reset_word: data=%h mask=%b required 13121110 1111",
               bus.o_output_data, bus.o_output_mask);
    end
    wait_empty("mid_reset");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    m_cnt  = 0;
    fork
      run_monitor();
    join_none
    test_reset();
    test_full_word();
    test_partial_word();
    test_last_on_full();
    test_backpressure();
    test_back_to_back();
    test_random_backpressure();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_packer.md
DATA_PACKER -- requirements
Module: data_packer

Interface
REQ-001 Parameter WIDTH, default 8, element width in bits.
REQ-002 Parameter RATIO, default 4, elements per packed word, >=2.
REQ-003 Parameter CNT_BIT, default $clog2(RATIO), lane counter width.
REQ-004 i_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_reset  input  1  reset, asynchronous, active-low.
REQ-006 o_input_ready  output  1  packer can accept an element this cycle.
REQ-007 i_input_valid  input  1  element present on i_input_data.
REQ-008 i_input_data  input  WIDTH  element.
REQ-009 i_input_last  input  1  element closes the current group; qualified by i_input_valid.
REQ-010 i_output_ready  input  1  downstream (word FIFO) can accept the packed word.
REQ-011 o_output_valid  output  1  packed word present.
REQ-012 o_output_data  output  RATIO*WIDTH  packed word; lane k = bits [k*WIDTH +: WIDTH].
REQ-013 o_output_mask  output  RATIO  bit k set = lane k holds a valid element.
REQ-014 o_output_last  output  1  word ends a group.

Function
REQ-015 Input accept = o_input_ready & i_input_valid; output transfer = i_output_ready & o_output_valid.
REQ-016 o_input_ready = !o_output_valid | i_output_ready; no combinational dependence on i_input_valid, i_input_data or i_input_last.
REQ-017 Internal state: lane counter cnt (CNT_BIT bits), accumulation register acc (RATIO*WIDTH bits), registered output word/mask/last/valid.
REQ-018 Accepted element with cnt < RATIO-1 and i_input_last=0 (non-completing): write to acc lane cnt, cnt <= cnt+1; output registers unaffected by it.
REQ-019 Accepted element with cnt == RATIO-1 or i_input_last=1 (completing): next cycle o_output_data = acc with lane cnt replaced by i_input_data and lanes above cnt zero; o_output_mask = bits 0..cnt set; o_output_last = i_input_last; o_output_valid = 1; cnt <= 0; acc <= 0.
REQ-020 Latency: packed word valid on the cycle after the completing element is accepted.
REQ-021 Output transfer with no completing accept in the same cycle: o_output_valid <= 0; data/mask/last may hold.
REQ-022 Output transfer and completing accept in the same cycle: new word loaded, o_output_valid stays 1; sustained throughput 1 element/cycle with i_output_ready held high.
REQ-023 o_output_valid=1 and i_output_ready=0: o_output_data, o_output_mask, o_output_last held stable; o_input_ready=0; cnt and acc unchanged.
REQ-024 i_input_last with cnt == RATIO-1: single word, full mask, o_output_last=1; no extra empty word.
REQ-025 No empty word ever produced; o_output_mask is never 0 while o_output_valid=1.
REQ-026 i_input_valid asserted while o_input_ready=0: element not consumed, no state change; upstream must hold it.
REQ-027 cnt wraps RATIO-1 -> 0 only on a completing accept; never exceeds RATIO-1.

Reset
REQ-028 i_reset low asynchronously forces cnt=0, acc=0, o_output_valid=0, o_output_data=0, o_output_mask=0, o_output_last=0.
REQ-029 Reset mid-group discards partial elements and any undelivered word; first element after reset lands in lane 0.
REQ-030 o_input_ready=1 during and immediately after reset.

Verification
REQ-031 RATIO=4, WIDTH=8, output ready high; accept 0x11,0x22,0x33,0x44 (last=0) -> one cycle after 4th accept: data 0x44332211, mask 4'b1111, last 0, valid for exactly one cycle.
REQ-032 Accept 0xAA, then 0xBB with last=1 -> data 0x0000BBAA, mask 4'b0011, last 1; next element lands in lane 0.
REQ-033 Single element 0x5C with last=1 at cnt=0 -> data 0x0000005C, mask 4'b0001, last 1.
REQ-034 Hold i_output_ready=0 for 5 cycles with word pending -> o_input_ready=0, word/mask/last unchanged; on release, word transfers and same-cycle completing element yields next word without bubble.
REQ-035 Continuous stream of 12 elements 0x01..0x0C, last on 0x0C, ready high -> three words 0x04030201, 0x08070605, 0x0C0B0A09 (last=1 on third), no input stall.
REQ-036 Accept 0x01, 0x02, assert i_reset low mid-cycle -> outputs zero immediately; after release accept 0x10..0x13 -> data 0x13121110, mask 4'b1111, no stale lanes.
